// File: rtl/cache_axi_bridge_pkg.sv
// rtl/cache_axi_bridge_pkg.sv - request types, AXI constants and FSM encodings for cache_axi_bridge
package cache_axi_pkg;

   localparam logic [2:0] TYPE_BYTE = 3'b000;
   localparam logic [2:0] TYPE_HALF = 3'b001;
   localparam logic [2:0] TYPE_WORD = 3'b010;
   localparam logic [2:0] TYPE_LINE = 3'b100;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam int         LINE_BEATS     = 4;

   localparam logic [1:0] R_IDLE = 2'd0;
   localparam logic [1:0] R_AR   = 2'd1;
   localparam logic [1:0] R_DATA = 2'd2;

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_AW   = 2'd1;
   localparam logic [1:0] W_DATA = 2'd2;
   localparam logic [1:0] W_RESP = 2'd3;

   // Only line requests burst; everything else is a single beat of its own size.
   function automatic logic [7:0] axi_len(input logic [2:0] t);
      return (t == TYPE_LINE) ? 8'(LINE_BEATS - 1) : 8'd0;
   endfunction

   function automatic logic [2:0] axi_size(input logic [2:0] t);
      return (t == TYPE_LINE) ? 3'd2 : {1'b0, t[1:0]};
   endfunction

endpackage

// File: rtl/cache_axi_bridge_if.sv
// rtl/cache_axi_bridge_if.sv - cache request/return and AXI4 master channel bundle
interface cache_axi_bridge_if;

   logic         rd_req;
   logic [3:0]   rd_type;
   logic [31:0]  rd_addr;
   logic         rd_rdy;
   logic         ret_valid;
   logic         ret_last;
   logic [31:0]  ret_data;
   logic         wr_req;
   logic [3:0]   wr_type;
   logic [31:0]  wr_addr;
   logic [3:0]   wr_wstrb;
   logic [127:0] wr_data;
   logic         wr_rdy;

   logic [3:0]   arid;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic [2:0]   arsize;
   logic [1:0]   arburst;
   logic [1:0]   arlock;
   logic [3:0]   arcache;
   logic [2:0]   arprot;
   logic         arvalid;
   logic         arready;
   logic [3:0]   rid;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rlast;
   logic         rvalid;
   logic         rready;
   logic [3:0]   awid;
   logic [31:0]  awaddr;
   logic [7:0]   awlen;
   logic [2:0]   awsize;
   logic [1:0]   awburst;
   logic [1:0]   awlock;
   logic [3:0]   awcache;
   logic [2:0]   awprot;
   logic         awvalid;
   logic         awready;
   logic [3:0]   wid;
   logic [31:0]  wdata;
   logic [3:0]   wstrb;
   logic         wlast;
   logic         wvalid;
   logic         wready;
   logic [3:0]   bid;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready;

   modport master (
      input  rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
      output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      output rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
      input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );

endinterface

// File: rtl/cache_axi_wr_engine.sv
// rtl/cache_axi_wr_engine.sv - write FSM, 128-bit line buffer and W beat counter
module cache_axi_wr_engine
   import cache_axi_pkg::*;
#(
   parameter logic [3:0] WR_ID = 4'd1
) (
   input  logic         i_clk,
   input  logic         i_resetn,
   input  logic         i_wr_req,
   input  logic [3:0]   i_wr_type,
   input  logic [31:0]  i_wr_addr,
   input  logic [3:0]   i_wr_wstrb,
   input  logic [127:0] i_wr_data,
   output logic         o_wr_rdy,
   output logic         o_busy,
   output logic [27:0]  o_line_addr,
   output logic [3:0]   o_awid,
   output logic [31:0]  o_awaddr,
   output logic [7:0]   o_awlen,
   output logic [2:0]   o_awsize,
   output logic [1:0]   o_awburst,
   output logic         o_awvalid,
   input  logic         i_awready,
   output logic [3:0]   o_wid,
   output logic [31:0]  o_wdata,
   output logic [3:0]   o_wstrb,
   output logic         o_wlast,
   output logic         o_wvalid,
   input  logic         i_wready,
   input  logic         i_bvalid,
   output logic         o_bready
);

   logic [1:0]   r_state;
   logic [31:0]  r_addr;
   logic [2:0]   r_type;
   logic [3:0]   r_wstrb;
   logic [127:0] r_data;
   logic [1:0]   r_cnt;
   logic [7:0]   w_len;
   logic         w_last_beat;
   logic         w_unused;

   assign w_len       = axi_len(r_type);
   assign w_last_beat = ({6'd0, r_cnt} == w_len);
   assign w_unused    = i_wr_type[3];

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state <= W_IDLE;
         r_addr  <= '0;
         r_type  <= '0;
         r_wstrb <= '0;
         r_data  <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            W_IDLE: if (i_wr_req) begin
               // Whole line is captured so the cache is free to change wr_data next cycle.
               r_state <= W_AW;
               r_addr  <= i_wr_addr;
               r_type  <= i_wr_type[2:0];
               r_wstrb <= i_wr_wstrb;
               r_data  <= i_wr_data;
            end
            W_AW: if (i_awready) r_state <= W_DATA;
            W_DATA: if (i_wready) begin
               if (w_last_beat) begin
                  r_state <= W_RESP;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 2'd1;
               end
            end
            W_RESP: if (i_bvalid) r_state <= W_IDLE;
            default: r_state <= W_IDLE;
         endcase
      end
   end

   assign o_wr_rdy    = (r_state == W_IDLE);
   assign o_busy      = (r_state != W_IDLE);
   assign o_line_addr = r_addr[31:4];

   assign o_awid    = WR_ID;
   assign o_awaddr  = r_addr;
   assign o_awlen   = w_len;
   assign o_awsize  = axi_size(r_type);
   assign o_awburst = AXI_BURST_INCR;
   assign o_awvalid = (r_state == W_AW);

   assign o_wid    = WR_ID;
   assign o_wdata  = r_data[{r_cnt, 5'd0} +: 32];
   assign o_wstrb  = (r_type == TYPE_LINE) ? 4'hf : r_wstrb;
   assign o_wvalid = (r_state == W_DATA);
   assign o_wlast  = (r_state == W_DATA) && w_last_beat;
   assign o_bready = (r_state == W_RESP);

endmodule

// File: rtl/cache_axi_bridge.sv
// rtl/cache_axi_bridge.sv - cache refill/write-back to AXI4 master bridge with read-after-write guard
// Optional macro CACHE_AXI_RAW_CHECK_EN: block reads only on a line-address match with the write.
module cache_axi_bridge
   import cache_axi_pkg::*;
#(
   parameter logic [3:0] RD_ID = 4'd0,
   parameter logic [3:0] WR_ID = 4'd1
) (
   input  logic            clk,
   input  logic            resetn,
   cache_axi_bridge_if.master bus
);

   logic [1:0]  r_rstate;
   logic [31:0] r_raddr;
   logic [2:0]  r_rtype;
   logic        w_wr_rdy;
   logic        w_wr_busy;
   logic [27:0] w_wr_line;
   logic        w_wr_accept;
   logic        w_raw_block;
   logic        w_rd_accept;
   logic        w_in_rdata;
   logic        w_unused;

   cache_axi_wr_engine #(.WR_ID(WR_ID)) u_wr_engine (
      .i_clk       (clk),
      .i_resetn    (resetn),
      .i_wr_req    (bus.wr_req),
      .i_wr_type   (bus.wr_type),
      .i_wr_addr   (bus.wr_addr),
      .i_wr_wstrb  (bus.wr_wstrb),
      .i_wr_data   (bus.wr_data),
      .o_wr_rdy    (w_wr_rdy),
      .o_busy      (w_wr_busy),
      .o_line_addr (w_wr_line),
      .o_awid      (bus.awid),
      .o_awaddr    (bus.awaddr),
      .o_awlen     (bus.awlen),
      .o_awsize    (bus.awsize),
      .o_awburst   (bus.awburst),
      .o_awvalid   (bus.awvalid),
      .i_awready   (bus.awready),
      .o_wid       (bus.wid),
      .o_wdata     (bus.wdata),
      .o_wstrb     (bus.wstrb),
      .o_wlast     (bus.wlast),
      .o_wvalid    (bus.wvalid),
      .i_wready    (bus.wready),
      .i_bvalid    (bus.bvalid),
      .o_bready    (bus.bready)
   );

   assign w_wr_accept = bus.wr_req & w_wr_rdy;

`ifdef CACHE_AXI_RAW_CHECK_EN
   assign w_raw_block = (w_wr_busy   && (bus.rd_addr[31:4] == w_wr_line)) ||
                        (w_wr_accept && (bus.rd_addr[31:4] == bus.wr_addr[31:4]));
`else
   assign w_raw_block = w_wr_busy || w_wr_accept;
`endif

   assign w_rd_accept = bus.rd_req && (r_rstate == R_IDLE) && !w_raw_block;
   assign w_in_rdata  = (r_rstate == R_DATA);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rstate <= R_IDLE;
         r_raddr  <= '0;
         r_rtype  <= '0;
      end else begin
         case (r_rstate)
            R_IDLE: if (w_rd_accept) begin
               r_rstate <= R_AR;
               r_raddr  <= bus.rd_addr;
               r_rtype  <= bus.rd_type[2:0];
            end
            R_AR:   if (bus.arready) r_rstate <= R_DATA;
            R_DATA: if (bus.rvalid && bus.rlast) r_rstate <= R_IDLE;
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

   assign bus.rd_rdy  = (r_rstate == R_IDLE) && !w_raw_block;
   assign bus.wr_rdy  = w_wr_rdy;

   assign bus.arid    = RD_ID;
   assign bus.araddr  = r_raddr;
   assign bus.arlen   = axi_len(r_rtype);
   assign bus.arsize  = axi_size(r_rtype);
   assign bus.arburst = AXI_BURST_INCR;
   assign bus.arvalid = (r_rstate == R_AR);
   assign bus.rready  = w_in_rdata;

   // Return path is a straight pass-through, qualified only so a stray rvalid outside a burst never reaches the cache.
   assign bus.ret_valid = bus.rvalid && w_in_rdata;
   assign bus.ret_last  = bus.rlast && w_in_rdata;
   assign bus.ret_data  = bus.rdata;

   assign bus.arlock  = '0;
   assign bus.arcache = '0;
   assign bus.arprot  = '0;
   assign bus.awlock  = '0;
   assign bus.awcache = '0;
   assign bus.awprot  = '0;

   assign w_unused = ^{bus.rid, bus.rresp, bus.bid, bus.bresp, bus.rd_type[3], w_wr_line};

endmodule

// File: tb/tb_cache_axi_bridge.sv
// tb/tb_cache_axi_bridge.sv - directed self-checking bench for cache_axi_bridge
module tb_cache_axi_bridge;
   import cache_axi_pkg::*;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

`ifdef CACHE_AXI_RAW_CHECK_EN
   localparam logic PAR_EXP = 1'b1;
`else
   localparam logic PAR_EXP = 1'b0;
`endif

   always #5 clk = ~clk;

   cache_axi_bridge_if bif();

   cache_axi_bridge #(.RD_ID(4'd0), .WR_ID(4'd1)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bif)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [3:0] typ, input int ar_wait,
                          input int beats, input logic [7:0] exp_len, input logic [2:0] exp_size,
                          input logic [31:0] d0);
      bif.rd_req  = 1'b1;
      bif.rd_type = typ;
      bif.rd_addr = addr;
      #1 check("rd_rdy_before", bif.rd_rdy, 1'b1);
      tick;
      bif.rd_req = 1'b0;
      #1;
      check("arvalid", bif.arvalid, 1'b1);
      check("araddr", bif.araddr, addr);
      check("arlen", bif.arlen, exp_len);
      check("arsize", bif.arsize, exp_size);
      check("arburst", bif.arburst, 2'b01);
      check("arid", bif.arid, 4'd0);
      repeat (ar_wait) tick;
      check("arvalid_hold", bif.arvalid, 1'b1);
      bif.arready = 1'b1;
      tick;
      bif.arready = 1'b0;
      #1;
      check("arvalid_drop", bif.arvalid, 1'b0);
      check("rready", bif.rready, 1'b1);
      for (int i = 0; i < beats; i++) begin
         bif.rvalid = 1'b1;
         bif.rdata  = d0 + 32'(i);
         bif.rlast  = (i == beats - 1);
         #1;
         check("ret_valid", bif.ret_valid, 1'b1);
         check("ret_data", bif.ret_data, d0 + 32'(i));
         check("ret_last", bif.ret_last, (i == beats - 1));
         tick;
      end
      bif.rvalid = 1'b0;
      bif.rlast  = 1'b0;
      #1 check("rd_rdy_after", bif.rd_rdy, 1'b1);
   endtask

   initial begin
      logic [31:0]  words [4];
      logic [5:0]   pat;
      logic [127:0] line;
      int           k;

      bif.rd_req = 0; bif.rd_type = 0; bif.rd_addr = 0;
      bif.wr_req = 0; bif.wr_type = 0; bif.wr_addr = 0; bif.wr_wstrb = 0; bif.wr_data = 0;
      bif.arready = 0; bif.rid = 0; bif.rdata = 0; bif.rresp = 0; bif.rlast = 0; bif.rvalid = 0;
      bif.awready = 0; bif.wready = 0; bif.bid = 0; bif.bresp = 0; bif.bvalid = 0;

      repeat (3) tick;
      check("rst_arvalid", bif.arvalid, 1'b0);
      check("rst_rready", bif.rready, 1'b0);
      check("rst_awvalid", bif.awvalid, 1'b0);
      check("rst_wvalid", bif.wvalid, 1'b0);
      check("rst_wlast", bif.wlast, 1'b0);
      check("rst_bready", bif.bready, 1'b0);
      check("rst_ret_valid", bif.ret_valid, 1'b0);
      resetn = 1'b1;
      tick;
      check("rst_rd_rdy", bif.rd_rdy, 1'b1);
      check("rst_wr_rdy", bif.wr_rdy, 1'b1);

      do_read(32'h1C000040, 4'b0100, 2, 4, 8'd3, 3'd2, 32'hA000_0000);
      do_read(32'hBFAF8003, 4'b0000, 0, 1, 8'd0, 3'd0, 32'h0000_0055);

      line     = 128'h33332222_11110000_DDDDCCCC_BBBBAAAA;
      words[0] = 32'hBBBBAAAA;
      words[1] = 32'hDDDDCCCC;
      words[2] = 32'h11110000;
      words[3] = 32'h33332222;
      bif.wr_req = 1'b1; bif.wr_type = 4'b0100; bif.wr_addr = 32'h00001230;
      bif.wr_wstrb = 4'h0; bif.wr_data = line;
      #1 check("lw_wr_rdy_pre", bif.wr_rdy, 1'b1);
      tick;
      bif.wr_req = 1'b0; bif.wr_data = '0;
      #1;
      check("lw_wr_rdy_busy", bif.wr_rdy, 1'b0);
      check("lw_awvalid", bif.awvalid, 1'b1);
      check("lw_awaddr", bif.awaddr, 32'h00001230);
      check("lw_awlen", bif.awlen, 8'd3);
      check("lw_awsize", bif.awsize, 3'd2);
      check("lw_awid", bif.awid, 4'd1);
      check("lw_w_before_aw", bif.wvalid, 1'b0);
      bif.awready = 1'b1;
      tick;
      bif.awready = 1'b0;
      pat = 6'b101101;
      k   = 0;
      for (int p = 0; p < 6; p++) begin
         bif.wready = pat[p];
         #1;
         check("lw_wvalid", bif.wvalid, 1'b1);
         check("lw_wdata", bif.wdata, words[k]);
         check("lw_wstrb", bif.wstrb, 4'hf);
         check("lw_wlast", bif.wlast, (k == 3));
         tick;
         if (pat[p]) k++;
      end
      bif.wready = 1'b0;
      #1;
      check("lw_bready", bif.bready, 1'b1);
      check("lw_wvalid_off", bif.wvalid, 1'b0);
      check("lw_wr_rdy_resp", bif.wr_rdy, 1'b0);
      tick;
      bif.bvalid = 1'b1;
      #1 check("lw_wr_rdy_bvalid", bif.wr_rdy, 1'b0);
      tick;
      bif.bvalid = 1'b0;
      #1 check("lw_wr_rdy_done", bif.wr_rdy, 1'b1);

      bif.wr_req = 1'b1; bif.wr_type = 4'b0010; bif.wr_addr = 32'h00001230;
      bif.wr_wstrb = 4'hf; bif.wr_data = 128'h12345678;
      tick;
      bif.wr_req = 1'b0;
      bif.rd_req = 1'b1; bif.rd_type = 4'b0010; bif.rd_addr = 32'h00001230;
      #1 check("raw_rd_rdy_aw", bif.rd_rdy, 1'b0);
      bif.awready = 1'b1;
      tick;
      bif.awready = 1'b0;
      bif.wready  = 1'b1;
      #1 check("raw_rd_rdy_w", bif.rd_rdy, 1'b0);
      tick;
      bif.wready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1 check("raw_rd_rdy_resp", bif.rd_rdy, 1'b0);
         tick;
      end
      bif.bvalid = 1'b1;
      #1 check("raw_rd_rdy_bvalid", bif.rd_rdy, 1'b0);
      tick;
      bif.bvalid = 1'b0;
      #1;
      check("raw_rd_rdy_free", bif.rd_rdy, 1'b1);
      check("raw_arvalid_pre", bif.arvalid, 1'b0);
      tick;
      bif.rd_req = 1'b0;
      #1;
      check("raw_arvalid", bif.arvalid, 1'b1);
      check("raw_araddr", bif.araddr, 32'h00001230);
      bif.arready = 1'b1;
      tick;
      bif.arready = 1'b0;
      bif.rvalid = 1'b1; bif.rlast = 1'b1; bif.rdata = 32'h12345678;
      #1 check("raw_ret_data", bif.ret_data, 32'h12345678);
      tick;
      bif.rvalid = 1'b0; bif.rlast = 1'b0;

      bif.wr_req = 1'b1; bif.wr_type = 4'b0010; bif.wr_addr = 32'h00001230;
      bif.wr_wstrb = 4'hf; bif.wr_data = 128'h1;
      tick;
      bif.wr_req = 1'b0;
      bif.rd_req = 1'b1; bif.rd_type = 4'b0010; bif.rd_addr = 32'h00002230;
      #1 check("par_rd_rdy", bif.rd_rdy, PAR_EXP);
      bif.awready = 1'b1;
      tick;
      bif.awready = 1'b0;
      bif.rd_req  = 1'b0;
      #1 check("par_arvalid", bif.arvalid, PAR_EXP);
      bif.wready = 1'b1; bif.arready = 1'b1;
      tick;
      bif.wready = 1'b0; bif.arready = 1'b0;
      bif.bvalid = 1'b1; bif.rvalid = 1'b1; bif.rlast = 1'b1;
      tick;
      bif.bvalid = 1'b0; bif.rvalid = 1'b0; bif.rlast = 1'b0;
      #1;
      check("par_rd_rdy_end", bif.rd_rdy, 1'b1);
      check("par_wr_rdy_end", bif.wr_rdy, 1'b1);

      bif.wr_req = 1'b1; bif.wr_type = 4'b0010; bif.wr_addr = 32'h00000008;
      bif.wr_wstrb = 4'b0110; bif.wr_data = 128'hCAFEF00D;
      tick;
      bif.wr_req = 1'b0;
      #1;
      check("ww_awlen", bif.awlen, 8'd0);
      check("ww_awsize", bif.awsize, 3'd2);
      check("ww_awaddr", bif.awaddr, 32'h00000008);
      bif.awready = 1'b1;
      tick;
      bif.awready = 1'b0;
      bif.wready  = 1'b1;
      #1;
      check("ww_wvalid", bif.wvalid, 1'b1);
      check("ww_wstrb", bif.wstrb, 4'b0110);
      check("ww_wlast", bif.wlast, 1'b1);
      check("ww_wdata", bif.wdata, 32'hCAFEF00D);
      tick;
      bif.wready = 1'b0;
      #1 check("ww_bready", bif.bready, 1'b1);
      bif.bvalid = 1'b1;
      tick;
      bif.bvalid = 1'b0;
      #1 check("ww_wr_rdy_done", bif.wr_rdy, 1'b1);

      bif.rd_req = 1'b1; bif.rd_type = 4'b0100; bif.rd_addr = 32'h00000100;
      tick;
      bif.rd_req  = 1'b0;
      bif.arready = 1'b1;
      tick;
      bif.arready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bif.rvalid = 1'b1; bif.rdata = 32'(i);
         tick;
      end
      bif.rdata = 32'h2;
      #1 check("mr_ret_valid_pre", bif.ret_valid, 1'b1);
      resetn = 1'b0;
      #1;
      check("mr_ret_valid", bif.ret_valid, 1'b0);
      check("mr_rready", bif.rready, 1'b0);
      check("mr_arvalid", bif.arvalid, 1'b0);
      check("mr_awvalid", bif.awvalid, 1'b0);
      check("mr_wvalid", bif.wvalid, 1'b0);
      bif.rvalid = 1'b0;
      tick;
      resetn = 1'b1;
      tick;
      check("mr_rd_rdy", bif.rd_rdy, 1'b1);
      check("mr_wr_rdy", bif.wr_rdy, 1'b1);
      do_read(32'h00000200, 4'b0100, 0, 4, 8'd3, 3'd2, 32'h5000_0000);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
